ahbl_sram_slave: RTL and testbench

//  AHB-Lite responder: word-organised on-chip SRAM, implemented as a register array.

---
 rtl/ahbl_sram_slave.sv | 142 ++++++++++++++
 tb/tb_ahbl_sram_slave.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahbl_sram_slave.sv
// ahbl_sram_slave -- AHB-Lite responder fronting a word-organised SRAM that is
// built from a register array. It serves the CPU as both instruction and data
// memory. Byte, halfword and word accesses are supported, every OKAY data phase
// carries WAIT_STATES wait cycles, and illegal transfers get a two-cycle ERROR.
//
// Parameters
//   AW          word-address width (depth = 2**AW words)
//   WAIT_STATES wait cycles inserted in every OKAY data phase (0..7)
//   BASE        byte address of word 0; HADDR[31:AW+2] must match BASE[31:AW+2]
//
// Ports
//   HCLK, HRESETn   clock, asynchronous active-low reset
//   HSEL, HADDR, HTRANS, HWRITE, HSIZE, HREADY   address-phase inputs
//   HWDATA          write data (data phase)
//   HRDATA          read data, full word, little-endian lanes (data phase)
//   HREADYOUT       0 inserts a wait state
//   HRESP           2'b00 OKAY, 2'b01 ERROR
//   fsm_state       current FSM state (0 IDLE, 1 DATA, 2 ERR1, 3 ERR2)
//
// Handshake: an address phase is taken on a rising edge where
// HSEL & HREADY & HTRANS[1]; the data phase ends on the first edge where
// HREADYOUT is 1. While HREADYOUT is 0 the master holds its next address.
module ahbl_sram_slave #(
  parameter int          AW          = 10,
  parameter int          WAIT_STATES = 0,
  parameter logic [31:0] BASE        = 32'h0
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
  output logic [31:0] HRDATA,
  output logic        HREADYOUT,
  output logic [1:0]  HRESP,
  output logic [1:0]  fsm_state
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_DATA = 2'd1;
  localparam logic [1:0] S_ERR1 = 2'd2;
  localparam logic [1:0] S_ERR2 = 2'd3;

  localparam logic [2:0] WS = 3'(WAIT_STATES);

  logic [1:0]    state, state_nxt;
  logic [2:0]    waitcnt;
  logic [AW-1:0] a_word;
  logic [1:0]    a_lane;
  logic [1:0]    a_size;
  logic          a_write;
  logic [3:0]    byte_en;

  logic [31:0] mem [0:(1<<AW)-1];

  logic accept, in_window, aligned, legal, data_done, phase_free;

  // HTRANS[0] only separates NONSEQ from SEQ, which this memory treats alike.
  logic unused_htrans0;
  assign unused_htrans0 = HTRANS[0];

  assign accept    = HSEL & HREADY & HTRANS[1];
  assign in_window = (HADDR[31:AW+2] == BASE[31:AW+2]);

  always_comb begin
    aligned = 1'b0;
    case (HSIZE)
      3'd0:    aligned = 1'b1;
      3'd1:    aligned = ~HADDR[0];
      3'd2:    aligned = (HADDR[1:0] == 2'b00);
      default: aligned = 1'b0;
    endcase
  end

  assign legal      = in_window & aligned;
  assign data_done  = (state == S_DATA) && (waitcnt == WS);
  // States in which the previous data phase is ending, so a new address may be taken.
  assign phase_free = (state == S_IDLE) || (state == S_ERR2) || data_done;

  always_comb begin
    state_nxt = state;
    if (state == S_ERR1) begin
      state_nxt = S_ERR2;
    end else if (phase_free) begin
      if (accept) state_nxt = legal ? S_DATA : S_ERR1;
      else        state_nxt = S_IDLE;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state   <= S_IDLE;
      waitcnt <= 3'd0;
      a_word  <= '0;
      a_lane  <= 2'b00;
      a_size  <= 2'b00;
      a_write <= 1'b0;
    end else begin
      state <= state_nxt;
      if (phase_free && accept) begin
        waitcnt <= 3'd0;
        a_word  <= HADDR[AW+1:2];
        a_lane  <= HADDR[1:0];
        a_size  <= HSIZE[1:0];
        a_write <= HWRITE;
      end else if ((state == S_DATA) && !data_done) begin
        waitcnt <= waitcnt + 3'd1;
      end
    end
  end

  always_comb begin
    byte_en = 4'b1111;
    case (a_size)
      2'd0:    byte_en = 4'b0001 << a_lane;
      2'd1:    byte_en = a_lane[1] ? 4'b1100 : 4'b0011;
      default: byte_en = 4'b1111;
    endcase
  end

  // Commit happens on the edge that ends the write's data phase. Reset forces
  // the FSM to IDLE, so a write still waiting when reset hits is dropped.
  always_ff @(posedge HCLK) begin
    if (data_done && a_write) begin
      for (int b = 0; b < 4; b++) begin
        if (byte_en[b]) mem[a_word][8*b +: 8] <= HWDATA[8*b +: 8];
      end
    end
  end

  // Read data is combinational from the array, so a read whose data phase
  // starts on the same edge that commits a write to that word sees the new value.
  assign HRDATA    = ((state == S_DATA) && !a_write) ? mem[a_word] : 32'h0;
  assign HREADYOUT = !((state == S_ERR1) || ((state == S_DATA) && (waitcnt != WS)));
  assign HRESP     = ((state == S_ERR1) || (state == S_ERR2)) ? 2'b01 : 2'b00;
  assign fsm_state = state;

endmodule

// File: tb/tb_ahbl_sram_slave.sv
module tb_ahbl_sram_slave;

  localparam logic [1:0] T_IDLE   = 2'b00;
  localparam logic [1:0] T_BUSY   = 2'b01;
  localparam logic [1:0] T_NONSEQ = 2'b10;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        sel0 = 1'b0, sel2 = 1'b0;
  logic [31:0] haddr = '0;
  logic [1:0]  htrans = T_IDLE;
  logic        hwrite = 1'b0;
  logic [2:0]  hsize = 3'd0;
  logic [31:0] hwdata = '0;

  logic [31:0] rd0, rd2;
  logic        ro0, ro2;
  logic [1:0]  resp0, resp2, st0, st2;

  int n_cmp = 0;
  int n_fail = 0;

  // Zero-wait instance; it is the only responder on its bus, so HREADY = HREADYOUT.
  ahbl_sram_slave #(.AW(10), .WAIT_STATES(0), .BASE(32'h0)) u0 (
    .HCLK(clk), .HRESETn(rst_n), .HSEL(sel0), .HADDR(haddr), .HTRANS(htrans),
    .HWRITE(hwrite), .HSIZE(hsize), .HWDATA(hwdata), .HREADY(ro0),
    .HRDATA(rd0), .HREADYOUT(ro0), .HRESP(resp0), .fsm_state(st0));

  // Two-wait-state instance.
  ahbl_sram_slave #(.AW(10), .WAIT_STATES(2), .BASE(32'h0)) u2 (
    .HCLK(clk), .HRESETn(rst_n), .HSEL(sel2), .HADDR(haddr), .HTRANS(htrans),
    .HWRITE(hwrite), .HSIZE(hsize), .HWDATA(hwdata), .HREADY(ro2),
    .HRDATA(rd2), .HREADYOUT(ro2), .HRESP(resp2), .fsm_state(st2));

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic addr_phase(input logic s0, input logic s2, input logic [31:0] a,
                            input logic w, input logic [2:0] sz);
    sel0 = s0; sel2 = s2; haddr = a; hwrite = w; hsize = sz; htrans = T_NONSEQ;
  endtask

  task automatic bus_idle();
    sel0 = 1'b0; sel2 = 1'b0; htrans = T_IDLE; hwrite = 1'b0;
  endtask

  // Single zero-wait write on u0 followed by an idle address phase.
  task automatic wr0(input logic [31:0] a, input logic [2:0] sz, input logic [31:0] d);
    addr_phase(1'b1, 1'b0, a, 1'b1, sz);
    tick();
    hwdata = d; bus_idle();
    @(negedge clk);
    n_cmp++; if (ro0 !== 1'b1 || resp0 !== 2'b00) begin n_fail++; $display("FAIL wr0_okay @%h got ready=%b resp=%b exp ready=1 resp=00", a, ro0, resp0); end
    tick();
  endtask

  task automatic rd0_chk(input logic [31:0] a, input logic [31:0] exp, input string name);
    addr_phase(1'b1, 1'b0, a, 1'b0, 3'd2);
    tick();
    bus_idle();
    @(negedge clk);
    n_cmp++; if (rd0 !== exp || ro0 !== 1'b1 || resp0 !== 2'b00) begin n_fail++; $display("FAIL %s got data=%h ready=%b resp=%b exp data=%h ready=1 resp=00", name, rd0, ro0, resp0, exp); end
    tick();
  endtask

  // Write on u2, counting wait cycles; the wait loop is bounded.
  task automatic wr2(input logic [31:0] a, input logic [31:0] d);
    int waits = 0;
    addr_phase(1'b0, 1'b1, a, 1'b1, 3'd2);
    tick();
    hwdata = d; bus_idle();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (ro2) break;
      waits++;
      tick();
    end
    n_cmp++; if (waits !== 2) begin n_fail++; $display("FAIL wr2_waits @%h got=%0d exp=2", a, waits); end
    tick();
  endtask

  task automatic rd2_chk(input logic [31:0] a, input logic [31:0] exp, input string name);
    int waits = 0;
    addr_phase(1'b0, 1'b1, a, 1'b0, 3'd2);
    tick();
    bus_idle();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (ro2) break;
      waits++;
      tick();
    end
    n_cmp++; if (waits !== 2 || rd2 !== exp || resp2 !== 2'b00) begin n_fail++; $display("FAIL %s got data=%h waits=%0d resp=%b exp data=%h waits=2 resp=00", name, rd2, waits, resp2, exp); end
    tick();
  endtask

  // Illegal transfer on u0: ERROR with HREADYOUT 0 then 1, then back to IDLE.
  task automatic err0(input logic [31:0] a, input logic w, input logic [2:0] sz, input string name);
    addr_phase(1'b1, 1'b0, a, w, sz);
    tick();
    hwdata = 32'hFFFF_FFFF; bus_idle();
    @(negedge clk);
    n_cmp++; if (ro0 !== 1'b0 || resp0 !== 2'b01) begin n_fail++; $display("FAIL %s_cycle1 got ready=%b resp=%b exp ready=0 resp=01", name, ro0, resp0); end
    tick();
    @(negedge clk);
    n_cmp++; if (ro0 !== 1'b1 || resp0 !== 2'b01 || rd0 !== 32'h0) begin n_fail++; $display("FAIL %s_cycle2 got ready=%b resp=%b data=%h exp ready=1 resp=01 data=0", name, ro0, resp0, rd0); end
    tick();
    @(negedge clk);
    n_cmp++; if (resp0 !== 2'b00 || st0 !== 2'd0) begin n_fail++; $display("FAIL %s_after got resp=%b state=%0d exp resp=00 state=0", name, resp0, st0); end
    tick();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    #12;
    n_cmp++; if (ro0 !== 1'b1 || resp0 !== 2'b00 || rd0 !== 32'h0 || st0 !== 2'd0) begin n_fail++; $display("FAIL reset_u0 got ready=%b resp=%b data=%h state=%0d exp 1/00/0/0", ro0, resp0, rd0, st0); end
    n_cmp++; if (ro2 !== 1'b1 || resp2 !== 2'b00 || rd2 !== 32'h0 || st2 !== 2'd0) begin n_fail++; $display("FAIL reset_u2 got ready=%b resp=%b data=%h state=%0d exp 1/00/0/0", ro2, resp2, rd2, st2); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_word_rw();
    addr_phase(1'b1, 1'b0, 32'h10, 1'b1, 3'd2);
    tick();
    hwdata = 32'hDEAD_BEEF;
    addr_phase(1'b1, 1'b0, 32'h10, 1'b0, 3'd2);
    @(negedge clk);
    n_cmp++; if (ro0 !== 1'b1) begin n_fail++; $display("FAIL word_wr_ready got=%b exp=1", ro0); end
    tick();
    bus_idle();
    @(negedge clk);
    n_cmp++; if (rd0 !== 32'hDEAD_BEEF || ro0 !== 1'b1) begin n_fail++; $display("FAIL word_rd got data=%h ready=%b exp data=deadbeef ready=1", rd0, ro0); end
    tick();
  endtask

  task automatic test_byte_lanes();
    wr0(32'h10, 3'd2, 32'h0000_0000);
    wr0(32'h11, 3'd0, 32'hAAAA_AAAA);
    rd0_chk(32'h10, 32'h0000_AA00, "byte_lane1");
    wr0(32'h12, 3'd1, 32'h1234_1234);
    rd0_chk(32'h10, 32'h1234_AA00, "half_upper");
  endtask

  task automatic test_wait_states();
    wr2(32'h10, 32'hA5A5_0010);
    wr2(32'h14, 32'h5A5A_0014);
    addr_phase(1'b0, 1'b1, 32'h10, 1'b0, 3'd2);
    tick();
    // Next address presented immediately and held through the waits.
    addr_phase(1'b0, 1'b1, 32'h14, 1'b0, 3'd2);
    @(negedge clk);
    n_cmp++; if (ro2 !== 1'b0) begin n_fail++; $display("FAIL ws_wait1 got=%b exp=0", ro2); end
    tick();
    @(negedge clk);
    n_cmp++; if (ro2 !== 1'b0) begin n_fail++; $display("FAIL ws_wait2 got=%b exp=0", ro2); end
    tick();
    @(negedge clk);
    n_cmp++; if (ro2 !== 1'b1 || rd2 !== 32'hA5A5_0010) begin n_fail++; $display("FAIL ws_data1 got ready=%b data=%h exp ready=1 data=a5a50010", ro2, rd2); end
    tick();
    bus_idle();
    @(negedge clk);
    n_cmp++; if (ro2 !== 1'b0 || st2 !== 2'd1) begin n_fail++; $display("FAIL ws_held_accept got ready=%b state=%0d exp ready=0 state=1", ro2, st2); end
    tick();
    @(negedge clk);
    n_cmp++; if (ro2 !== 1'b0) begin n_fail++; $display("FAIL ws_held_wait2 got=%b exp=0", ro2); end
    tick();
    @(negedge clk);
    n_cmp++; if (ro2 !== 1'b1 || rd2 !== 32'h5A5A_0014) begin n_fail++; $display("FAIL ws_data2 got ready=%b data=%h exp ready=1 data=5a5a0014", ro2, rd2); end
    tick();
  endtask

  task automatic test_error();
    err0(32'h13, 1'b1, 3'd2, "err_unaligned_word");
    err0(32'h11, 1'b1, 3'd1, "err_unaligned_half");
    err0(32'h10, 1'b1, 3'd3, "err_size3");
    err0(32'h1010, 1'b1, 3'd2, "err_window_wr");
    err0(32'h1010, 1'b0, 3'd2, "err_window_rd");
    rd0_chk(32'h10, 32'h1234_AA00, "err_mem_unchanged");
    // A transfer presented during ERR2 is accepted normally.
    addr_phase(1'b1, 1'b0, 32'h13, 1'b1, 3'd2);
    tick();
    bus_idle();
    tick();
    addr_phase(1'b1, 1'b0, 32'h10, 1'b0, 3'd2);
    @(negedge clk);
    n_cmp++; if (ro0 !== 1'b1 || resp0 !== 2'b01) begin n_fail++; $display("FAIL err2_present got ready=%b resp=%b exp ready=1 resp=01", ro0, resp0); end
    tick();
    bus_idle();
    @(negedge clk);
    n_cmp++; if (rd0 !== 32'h1234_AA00 || resp0 !== 2'b00 || ro0 !== 1'b1) begin n_fail++; $display("FAIL err2_accept got data=%h resp=%b ready=%b exp data=1234aa00 resp=00 ready=1", rd0, resp0, ro0); end
    tick();
  endtask

  task automatic test_back_to_back();
    addr_phase(1'b1, 1'b0, 32'h20, 1'b1, 3'd2);
    tick();
    hwdata = 32'h0000_0005;
    addr_phase(1'b1, 1'b0, 32'h20, 1'b0, 3'd2);
    @(negedge clk);
    n_cmp++; if (ro0 !== 1'b1) begin n_fail++; $display("FAIL b2b_wr1_ready got=%b exp=1", ro0); end
    tick();
    addr_phase(1'b1, 1'b0, 32'h24, 1'b1, 3'd2);
    @(negedge clk);
    n_cmp++; if (rd0 !== 32'h5 || ro0 !== 1'b1) begin n_fail++; $display("FAIL b2b_rd1 got data=%h ready=%b exp data=00000005 ready=1", rd0, ro0); end
    tick();
    hwdata = 32'h0000_0077;
    addr_phase(1'b1, 1'b0, 32'h24, 1'b0, 3'd2);
    @(negedge clk);
    n_cmp++; if (ro0 !== 1'b1) begin n_fail++; $display("FAIL b2b_wr2_ready got=%b exp=1", ro0); end
    tick();
    bus_idle();
    @(negedge clk);
    n_cmp++; if (rd0 !== 32'h77 || ro0 !== 1'b1) begin n_fail++; $display("FAIL b2b_rd2 got data=%h ready=%b exp data=00000077 ready=1", rd0, ro0); end
    tick();
    // Selected but IDLE, then BUSY: OKAY, zero wait, no write.
    for (int i = 0; i < 4; i++) begin
      sel0 = 1'b1; haddr = 32'h20; hwrite = 1'b1; hsize = 3'd2;
      htrans = (i < 2) ? T_IDLE : T_BUSY;
      hwdata = 32'hFFFF_FFFF;
      tick();
      @(negedge clk);
      n_cmp++; if (ro0 !== 1'b1 || resp0 !== 2'b00 || st0 !== 2'd0) begin n_fail++; $display("FAIL idle_busy_%0d got ready=%b resp=%b state=%0d exp 1/00/0", i, ro0, resp0, st0); end
      tick();
    end
    bus_idle();
    rd0_chk(32'h20, 32'h0000_0005, "idle_no_access");
  endtask

  task automatic test_reset_mid_write();
    addr_phase(1'b0, 1'b1, 32'h10, 1'b1, 3'd2);
    tick();
    hwdata = 32'h0BAD_F00D; bus_idle();
    @(negedge clk);
    n_cmp++; if (ro2 !== 1'b0) begin n_fail++; $display("FAIL rst_mid_wait got=%b exp=0", ro2); end
    #1 rst_n = 1'b0;
    #1;
    n_cmp++; if (ro2 !== 1'b1 || resp2 !== 2'b00 || st2 !== 2'd0 || rd2 !== 32'h0) begin n_fail++; $display("FAIL rst_mid_async got ready=%b resp=%b state=%0d data=%h exp 1/00/0/0", ro2, resp2, st2, rd2); end
    #1 rst_n = 1'b1;
    tick();
    rd2_chk(32'h10, 32'hA5A5_0010, "rst_mid_unchanged");
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_word_rw();
    test_byte_lanes();
    test_wait_states();
    test_error();
    test_back_to_back();
    test_reset_mid_write();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=no_finish exp=finish");
    $fatal(1, "timeout");
  end

endmodule
